// File: rtl/serial_master_port.sv
// Master-side bus port: takes one parallel request, serialises slave select and
// the command frame towards the arbiter/bus, collects serial read data, reports completion.
module serial_master_port #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RX_TIMEOUT = 255
) (
  input  logic              MASTER_CLK,
  input  logic              MASTER_RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_slave,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              M_RQST,
  output logic              M_slave_SEL,
  input  logic              M_GRANT,
  input  logic              ARB_BUSY,
  input  logic              BUS_BUSY,
  output logic              M_TX,
  output logic              M_TX_VALID,
  input  logic              M_RX,
  input  logic              M_RX_VALID,
  output logic              tx_done
);

  localparam int unsigned FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned IDX_W   = $clog2(FRAME_W);
  localparam int unsigned TO_W    = $clog2(RX_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] WR_LAST = IDX_W'(FRAME_W - 1);
  localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(ADDR_W);
  localparam logic [IDX_W-1:0] RX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SEL1,
    S_WAIT_GNT,
    S_TX,
    S_RX,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         slave_q, slave_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TO_W-1:0]    tcnt_q, tcnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  always_ff @(posedge MASTER_CLK) begin
    if (MASTER_RST) begin
      state_q <= S_IDLE;
      slave_q <= '0;
      frame_q <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slave_q <= slave_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slave_d     = slave_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    tcnt_d      = tcnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = '0;
    M_RQST      = 1'b0;
    M_slave_SEL = 1'b0;
    M_TX        = 1'b0;
    M_TX_VALID  = 1'b0;
    tx_done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // frame bit 0 is the write flag, so frame_q[0] doubles as the op type
          frame_d = {req_wdata, req_addr, req_write};
          slave_d = req_slave;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        M_RQST      = 1'b1;
        M_slave_SEL = slave_q[0];
        if (!ARB_BUSY && !BUS_BUSY) state_d = S_SEL1;
      end
      S_SEL1: begin
        M_RQST      = 1'b1;
        M_slave_SEL = slave_q[1];
        state_d     = S_WAIT_GNT;
      end
      S_WAIT_GNT: begin
        M_RQST = 1'b1;
        if (M_GRANT) begin
          state_d = S_TX;
          idx_d   = '0;
        end else if (BUS_BUSY) begin
          state_d = S_REQ;
        end
      end
      S_TX: begin
        M_RQST = 1'b1;
        if (M_GRANT) begin
          M_TX_VALID = 1'b1;
          M_TX       = frame_q[idx_q];
          if (idx_q == (frame_q[0] ? WR_LAST : RD_LAST)) begin
            state_d = frame_q[0] ? S_DONE : S_RX;
            idx_d   = '0;
            tcnt_d  = '0;
            rdata_d = '0;
            err_d   = 1'b0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RX: begin
        M_RQST = 1'b1;
        if (M_GRANT) begin
          if (M_RX_VALID) begin
            rdata_d = {M_RX, rdata_q[DATA_W-1:1]};
            tcnt_d  = '0;
            if (idx_q == RX_LAST) state_d = S_DONE;
            else idx_d = idx_q + 1'b1;
          end else if (tcnt_q == TO_LAST) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        tx_done   = 1'b1;
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = rdata_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_master_port.sv
// Randomised bench for serial_master_port: plays the arbiter/slave side and
// checks every cycle against a transaction-level expectation of the port.
module tb_serial_master_port;

  localparam int TO = 16;

  logic        MASTER_CLK = 1'b0;
  logic        MASTER_RST;
  logic        req_valid, req_ready, req_write;
  logic [1:0]  req_slave;
  logic [11:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        M_RQST, M_slave_SEL, M_GRANT, ARB_BUSY, BUS_BUSY;
  logic        M_TX, M_TX_VALID, M_RX, M_RX_VALID, tx_done;

  serial_master_port #(.ADDR_W(12), .DATA_W(8), .RX_TIMEOUT(TO)) dut (
    .MASTER_CLK(MASTER_CLK), .MASTER_RST(MASTER_RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_slave(req_slave), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .M_RQST(M_RQST), .M_slave_SEL(M_slave_SEL), .M_GRANT(M_GRANT),
    .ARB_BUSY(ARB_BUSY), .BUS_BUSY(BUS_BUSY), .M_TX(M_TX), .M_TX_VALID(M_TX_VALID),
    .M_RX(M_RX), .M_RX_VALID(M_RX_VALID), .tx_done(tx_done)
  );

  always #5 MASTER_CLK = ~MASTER_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] cap_frame;
  int          cap_nbits, cap_idle_rx, cap_sel_pairs;
  logic [7:0]  cap_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ARB_BUSY = 0; BUS_BUSY = 0; M_GRANT = 0; M_RX = 0; M_RX_VALID = 0;
  endtask

  task automatic garbage_req(input bit rnd);
    req_valid = rnd && ($urandom_range(0, 1) == 1);
    if (req_valid) begin
      req_write = 1'($urandom); req_slave = 2'($urandom);
      req_addr = 12'($urandom); req_wdata = 8'($urandom);
    end
  endtask

  // mode: 0 normal, 1 split after bit 5, 2 contention in WAIT_GNT, 3 read timeout, 4 reset mid-TX
  task automatic do_txn(input bit wr, input logic [1:0] sl, input logic [11:0] ad,
                        input logic [7:0] wd, input logic [7:0] rd, input int mode,
                        input bit rnd, input bit b2b);
    bit q[$];
    int k, guard, stage, hold, split_left, rx_j, idle_cnt;
    bit contended, split_done, exp_err;
    q.delete();
    q.push_back(wr);
    for (int i = 0; i < 12; i++) q.push_back(ad[i]);
    if (wr) for (int i = 0; i < 8; i++) q.push_back(wd[i]);
    cap_frame = '0; cap_nbits = 0; cap_sel_pairs = 0; cap_idle_rx = 0;
    contended = 0; split_done = 0; split_left = 0; hold = 0;

    if (!b2b) @(negedge MASTER_CLK);
    req_valid = 1; req_write = wr; req_slave = sl; req_addr = ad; req_wdata = wd;
    idle_inputs();
    #1;
    chk("accept_ready", req_ready, 1);
    chk("accept_rqst", M_RQST, 0);

    stage = 0; guard = 0;
    while (stage != 3) begin
      @(negedge MASTER_CLK);
      garbage_req(rnd);
      idle_inputs();
      if (stage == 0) begin
        if (hold > 0) begin BUS_BUSY = 1; hold--; end
        else if (rnd) begin
          ARB_BUSY = ($urandom_range(0, 3) == 0);
          BUS_BUSY = ($urandom_range(0, 3) == 0);
        end
      end else if (stage == 2) begin
        if (mode == 2 && !contended) BUS_BUSY = 1;
        else begin
          M_GRANT = !rnd || ($urandom_range(0, 2) != 0);
          if (!M_GRANT) BUS_BUSY = 1'($urandom);
        end
      end
      #1;
      chk("sel_rqst", M_RQST, 1);
      chk("sel_ready", req_ready, 0);
      chk("sel_txv", M_TX_VALID, 0);
      chk("sel_done", {tx_done, rsp_valid}, 0);
      case (stage)
        0: begin
          chk("sel_bit0", M_slave_SEL, sl[0]);
          if (!ARB_BUSY && !BUS_BUSY) stage = 1;
        end
        1: begin
          chk("sel_bit1", M_slave_SEL, sl[1]);
          cap_sel_pairs++;
          stage = 2;
        end
        default: begin
          chk("sel_wait", M_slave_SEL, 0);
          if (M_GRANT) stage = 3;
          else if (BUS_BUSY) begin
            stage = 0;
            if (mode == 2 && !contended) begin contended = 1; hold = 3; end
          end
        end
      endcase
      if (++guard > 300) begin
        chk("sel_timeout", 0, 1);
        return;
      end
    end

    k = 0; guard = 0;
    while (k < q.size()) begin
      if (mode == 4 && k == 8) begin
        @(negedge MASTER_CLK);
        MASTER_RST = 1; req_valid = 0; M_GRANT = 1;
        @(negedge MASTER_CLK);
        MASTER_RST = 0; M_GRANT = 1;
        #1;
        chk("rst_rqst", M_RQST, 0);
        chk("rst_txv", M_TX_VALID, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_done", {tx_done, rsp_valid}, 0);
        for (int i = 0; i < 3; i++) begin
          @(negedge MASTER_CLK);
          #1;
          chk("rst_quiet", {tx_done, rsp_valid, M_RQST}, 0);
        end
        return;
      end
      @(negedge MASTER_CLK);
      garbage_req(rnd);
      idle_inputs();
      if (rnd) begin ARB_BUSY = 1'($urandom); BUS_BUSY = 1'($urandom); end
      if (mode == 1 && k == 6 && !split_done) begin split_left = 40; split_done = 1; end
      M_GRANT = (split_left > 0) ? 1'b0 : (!rnd || ($urandom_range(0, 3) != 0));
      if (split_left > 0) split_left--;
      #1;
      chk("tx_rqst", M_RQST, 1);
      chk("tx_done_early", {tx_done, rsp_valid}, 0);
      chk("tx_sel", M_slave_SEL, 0);
      chk("tx_valid", M_TX_VALID, M_GRANT);
      if (M_GRANT) begin
        chk("tx_bit", M_TX, q[k]);
        cap_frame[k] = M_TX;
        k++;
      end
      if (++guard > 400) begin
        chk("tx_timeout", 0, 1);
        return;
      end
    end
    cap_nbits = k;

    exp_err = 0;
    if (!wr) begin
      rx_j = 0; idle_cnt = 0; guard = 0;
      forever begin
        @(negedge MASTER_CLK);
        garbage_req(rnd);
        idle_inputs();
        M_GRANT = !rnd || ($urandom_range(0, 3) != 0);
        if (mode == 3) M_RX_VALID = !M_GRANT && ($urandom_range(0, 1) == 1);
        else M_RX_VALID = (idle_cnt >= TO - 2) || ($urandom_range(0, 1) == 1);
        M_RX = (M_GRANT && M_RX_VALID) ? rd[rx_j] : 1'($urandom);
        #1;
        chk("rx_rqst", M_RQST, 1);
        chk("rx_txv", M_TX_VALID, 0);
        chk("rx_done_early", {tx_done, rsp_valid}, 0);
        if (M_GRANT) begin
          if (M_RX_VALID) begin rx_j++; idle_cnt = 0; end
          else begin idle_cnt++; cap_idle_rx++; end
        end
        if (rx_j == 8) break;
        if (idle_cnt == TO) begin exp_err = 1; break; end
        if (++guard > 500) begin
          chk("rx_timeout_bound", 0, 1);
          return;
        end
      end
    end

    @(negedge MASTER_CLK);
    garbage_req(rnd);
    idle_inputs();
    M_GRANT = 1'($urandom);
    #1;
    chk("done_txdone", tx_done, 1);
    chk("done_rspv", rsp_valid, 1);
    chk("done_err", rsp_err, exp_err);
    chk("done_rqst", M_RQST, 0);
    chk("done_ready", req_ready, 0);
    if (!wr) chk("done_rdata", rsp_rdata, exp_err ? 8'h00 : rd);
    cap_rdata = rsp_rdata;

    @(negedge MASTER_CLK);
    req_valid = 0;
    idle_inputs();
    #1;
    chk("post_ready", req_ready, 1);
    chk("post_rqst", M_RQST, 0);
    chk("post_done", {tx_done, rsp_valid}, 0);
  endtask

  initial begin
    logic [1:0] sl;
    MASTER_RST = 1; req_valid = 0; req_write = 0; req_slave = 0; req_addr = 0; req_wdata = 0;
    idle_inputs();
    repeat (3) @(negedge MASTER_CLK);
    MASTER_RST = 0;
    #1;
    chk("reset_ready", req_ready, 1);
    chk("reset_outs", {M_RQST, M_slave_SEL, M_TX, M_TX_VALID, tx_done, rsp_valid, rsp_err}, 0);
    chk("reset_rdata", rsp_rdata, 0);

    do_txn(1, 2'b10, 12'hA5C, 8'h3C, 8'h00, 0, 0, 0);
    chk("lit_write_frame", cap_frame, 32'h794B9);
    chk("lit_write_len", cap_nbits, 21);

    do_txn(0, 2'b01, 12'h001, 8'h00, 8'h96, 0, 0, 0);
    chk("lit_read_frame", cap_frame, 32'h2);
    chk("lit_read_len", cap_nbits, 13);
    chk("lit_read_data", cap_rdata, 8'h96);

    do_txn(1, 2'b11, 12'h5A3, 8'hC7, 8'h00, 1, 0, 0);
    chk("lit_split_len", cap_nbits, 21);

    do_txn(1, 2'b01, 12'h0F0, 8'h81, 8'h00, 2, 0, 0);
    chk("lit_contend_pairs", cap_sel_pairs, 2);

    do_txn(0, 2'b10, 12'h333, 8'h00, 8'hFF, 3, 0, 0);
    chk("lit_timeout_cycles", cap_idle_rx, 16);
    chk("lit_timeout_rdata", cap_rdata, 0);

    do_txn(1, 2'b11, 12'hFFF, 8'hFF, 8'h00, 4, 0, 0);

    for (int t = 0; t < 40; t++) begin
      sl = 2'($urandom_range(1, 3));
      do_txn(1'($urandom), sl, 12'($urandom), 8'($urandom), 8'($urandom), 0, 1,
             1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
